// File: rtl/ysyx_25040111_csr_seq.sv
// CSR access sequencer: turns one CSR/ECALL/MRET request into timed CSR-file strobes.
// Optional YSYX_25040111_CSR_MSTATUS_EN adds an mstatus update state on ECALL/MRET.
module ysyx_25040111_csr_seq #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [CSR_AW-1:0] req_addr,
  input  logic [XLEN-1:0]   req_src,
  input  logic              req_rs1_zero,
  input  logic [XLEN-1:0]   req_pc,
  output logic              csr_wen,
  output logic [CSR_AW-1:0] csr_waddr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              csr_ren,
  output logic [CSR_AW-1:0] csr_raddr,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic [1:0]        csr_jtype,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_redirect,
  output logic [XLEN-1:0]   rsp_target,
  output logic              rsp_illegal
);

  localparam logic [2:0] OP_RW    = 3'd0;
  localparam logic [2:0] OP_RS    = 3'd1;
  localparam logic [2:0] OP_RC    = 3'd2;
  localparam logic [2:0] OP_ECALL = 3'd3;
  localparam logic [2:0] OP_MRET  = 3'd4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ACC   = 3'd1;
  localparam logic [2:0] S_EPC   = 3'd2;
  localparam logic [2:0] S_CAUSE = 3'd3;
  localparam logic [2:0] S_TVEC  = 3'd4;
  localparam logic [2:0] S_MEPC  = 3'd5;
  localparam logic [2:0] S_MST   = 3'd6;
  localparam logic [2:0] S_RSP   = 3'd7;

  localparam logic [CSR_AW-1:0] A_MSTATUS = CSR_AW'(12'h300);
  localparam logic [CSR_AW-1:0] A_MTVEC   = CSR_AW'(12'h305);
  localparam logic [CSR_AW-1:0] A_MEPC    = CSR_AW'(12'h341);

  logic [2:0]        r_state;
  logic [2:0]        r_op;
  logic [CSR_AW-1:0] r_addr;
  logic [XLEN-1:0]   r_src;
  logic              r_rs1z;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rdata;
  logic [XLEN-1:0]   r_target;
  logic              r_redirect;
  logic              r_illegal;

  logic              w_ro;
  logic              w_nowr;
  logic [XLEN-1:0]   w_acc_wdata;
  logic [2:0]        w_trap_next;

`ifdef YSYX_25040111_CSR_MSTATUS_EN
  // ECALL stacks MIE into MPIE; MRET restores it. MPP is forced to M either way.
  function automatic logic [XLEN-1:0] mstatus_upd(input logic [XLEN-1:0] old, input logic is_ecall);
    logic [XLEN-1:0] v;
    v = old;
    if (is_ecall) begin
      v[7] = old[3];
      v[3] = 1'b0;
    end else begin
      v[3] = old[7];
      v[7] = 1'b1;
    end
    v[12:11] = 2'b11;
    return v;
  endfunction
  assign w_trap_next = S_MST;
`else
  assign w_trap_next = S_RSP;
`endif

  assign w_ro   = (r_addr[11:10] == 2'b11);
  assign w_nowr = ((r_op == OP_RS) || (r_op == OP_RC)) && r_rs1z;

  always_comb begin
    case (r_op)
      OP_RW:   w_acc_wdata = r_src;
      OP_RS:   w_acc_wdata = csr_rdata | r_src;
      default: w_acc_wdata = csr_rdata & ~r_src;
    endcase
  end

  assign req_ready    = (r_state == S_IDLE);
  assign rsp_valid    = (r_state == S_RSP);
  assign rsp_rdata    = r_rdata;
  assign rsp_target   = r_target;
  assign rsp_redirect = r_redirect;
  assign rsp_illegal  = r_illegal;

  // Strobes are a pure function of state; IDLE (and therefore reset) drives them all low.
  always_comb begin
    csr_wen   = 1'b0;
    csr_waddr = '0;
    csr_wdata = '0;
    csr_ren   = 1'b0;
    csr_raddr = '0;
    csr_jtype = 2'b00;
    case (r_state)
      S_ACC: begin
        csr_ren   = 1'b1;
        csr_raddr = r_addr;
        csr_wen   = !w_nowr && !w_ro;
        csr_waddr = r_addr;
        csr_wdata = w_acc_wdata;
      end
      S_EPC: begin
        csr_wen   = 1'b1;
        csr_waddr = A_MEPC;
        csr_wdata = r_pc;
      end
      S_CAUSE: csr_jtype = 2'b01;
      S_TVEC: begin
        csr_ren   = 1'b1;
        csr_raddr = A_MTVEC;
      end
      S_MEPC: begin
        csr_ren   = 1'b1;
        csr_raddr = A_MEPC;
      end
`ifdef YSYX_25040111_CSR_MSTATUS_EN
      S_MST: begin
        csr_ren   = 1'b1;
        csr_raddr = A_MSTATUS;
        csr_wen   = 1'b1;
        csr_waddr = A_MSTATUS;
        csr_wdata = mstatus_upd(csr_rdata, r_op == OP_ECALL);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_addr     <= '0;
      r_src      <= '0;
      r_rs1z     <= 1'b0;
      r_pc       <= '0;
      r_rdata    <= '0;
      r_target   <= '0;
      r_redirect <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op       <= req_op;
            r_addr     <= req_addr;
            r_src      <= req_src;
            r_rs1z     <= req_rs1_zero;
            r_pc       <= req_pc;
            r_rdata    <= '0;
            r_target   <= '0;
            r_redirect <= 1'b0;
            r_illegal  <= 1'b0;
            case (req_op)
              OP_RW, OP_RS, OP_RC: r_state <= S_ACC;
              OP_ECALL:            r_state <= S_EPC;
              OP_MRET:             r_state <= S_MEPC;
              default: begin
                r_illegal <= 1'b1;
                r_state   <= S_RSP;
              end
            endcase
          end
        end
        S_ACC: begin
          r_rdata   <= csr_rdata;
          r_illegal <= w_ro && !w_nowr;
          r_state   <= S_RSP;
        end
        S_EPC:   r_state <= S_CAUSE;
        S_CAUSE: r_state <= S_TVEC;
        S_TVEC: begin
          r_target   <= csr_rdata & {{(XLEN-2){1'b1}}, 2'b00};
          r_redirect <= 1'b1;
          r_state    <= w_trap_next;
        end
        S_MEPC: begin
          r_target   <= csr_rdata;
          r_redirect <= 1'b1;
          r_state    <= w_trap_next;
        end
        S_RSP: begin
          if (rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_RSP;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040111_csr_seq.sv
// Randomized bench for ysyx_25040111_csr_seq: a behavioural CSR file answers the DUT strobes,
// and an operation-level reference model predicts responses and CSR contents.
module tb_ysyx_25040111_csr_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_rs1_zero;
  logic [2:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_src, req_pc;
  logic        csr_wen, csr_ren;
  logic [11:0] csr_waddr, csr_raddr;
  logic [31:0] csr_wdata, csr_rdata;
  logic [1:0]  csr_jtype;
  logic        rsp_valid, rsp_ready, rsp_redirect, rsp_illegal;
  logic [31:0] rsp_rdata, rsp_target;

  int n_chk = 0;
  int n_err = 0;
  int n_wen = 0;
  int n_jt = 0;
  int n_both = 0;

  logic [31:0] csr_mem [0:4095] = '{default: 32'h0};
  logic [31:0] m_csr   [0:4095] = '{default: 32'h0};

  always #5 clk = ~clk;

  ysyx_25040111_csr_seq #(.XLEN(32), .CSR_AW(12)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .req_src(req_src), .req_rs1_zero(req_rs1_zero), .req_pc(req_pc),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_ren(csr_ren), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_jtype(csr_jtype),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_redirect(rsp_redirect), .rsp_target(rsp_target), .rsp_illegal(rsp_illegal)
  );

  // CSR file: mvendorid is a hard-wired read-only constant
  assign csr_rdata = (csr_raddr == 12'hF11) ? 32'h79737978 : csr_mem[csr_raddr];

  always @(posedge clk) begin
    if (csr_wen) csr_mem[csr_waddr] <= csr_wdata;
    if (csr_jtype == 2'b01) csr_mem[12'h342] <= 32'd11;
    if (csr_wen) n_wen <= n_wen + 1;
    if (csr_jtype != 2'b00) n_jt <= n_jt + 1;
    if (csr_wen && csr_jtype != 2'b00) n_both <= n_both + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [11:0] a);
    return (a == 12'hF11) ? 32'h79737978 : m_csr[a];
  endfunction

  task automatic run_txn(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src,
                         input logic rz, input logic [31:0] pc, input int hold, input string nm);
    logic [31:0] e_rdata, e_tgt, old, ms;
    logic        e_red, e_ill, wr;
    int          e_lat, e_wen, e_jt, lat, w0, j0, b0;
    e_rdata = 0; e_tgt = 0; e_red = 0; e_ill = 0; e_wen = 0; e_jt = 0; e_lat = 1;
    case (op)
      3'd0, 3'd1, 3'd2: begin
        old = m_rd(addr);
        e_rdata = old;
        e_lat = 2;
        wr = !((op != 3'd0) && rz);
        if (wr && addr[11:10] == 2'b11) e_ill = 1;
        else if (wr) begin
          e_wen = 1;
          m_csr[addr] = (op == 3'd0) ? src : (op == 3'd1) ? (old | src) : (old & ~src);
        end
      end
      3'd3: begin
        m_csr[12'h341] = pc;
        m_csr[12'h342] = 32'd11;
        e_wen = 1; e_jt = 1; e_red = 1; e_lat = 4;
        e_tgt = m_csr[12'h305] & 32'hFFFF_FFFC;
`ifdef YSYX_25040111_CSR_MSTATUS_EN
        ms = m_csr[12'h300];
        m_csr[12'h300] = {ms[31:13], 2'b11, ms[10:8], ms[3], ms[6:4], 1'b0, ms[2:0]};
        e_wen = 2; e_lat = 5;
`endif
      end
      3'd4: begin
        e_red = 1; e_lat = 2;
        e_tgt = m_csr[12'h341];
`ifdef YSYX_25040111_CSR_MSTATUS_EN
        ms = m_csr[12'h300];
        m_csr[12'h300] = {ms[31:13], 2'b11, ms[10:8], 1'b1, ms[6:4], ms[7], ms[2:0]};
        e_wen = 1; e_lat = 3;
`endif
      end
      default: e_ill = 1;
    endcase

    @(negedge clk);
    chk({nm, ".req_ready"}, {31'b0, req_ready}, 32'd1);
    w0 = n_wen; j0 = n_jt; b0 = n_both;
    req_valid = 1; req_op = op; req_addr = addr; req_src = src; req_rs1_zero = rz; req_pc = pc;
    @(posedge clk); #1;
    req_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, ".latency"}, lat, e_lat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({nm, ".held_valid"}, {31'b0, rsp_valid}, 32'd1);
    end
    chk({nm, ".rdata"}, rsp_rdata, e_rdata);
    chk({nm, ".redirect"}, {31'b0, rsp_redirect}, {31'b0, e_red});
    chk({nm, ".illegal"}, {31'b0, rsp_illegal}, {31'b0, e_ill});
    if (e_red) chk({nm, ".target"}, rsp_target, e_tgt);
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk({nm, ".rsp_done"}, {30'b0, rsp_valid, req_ready}, 32'd1);
    chk({nm, ".wen_count"}, n_wen - w0, e_wen);
    chk({nm, ".jtype_count"}, n_jt - j0, e_jt);
    chk({nm, ".wen_with_jtype"}, n_both - b0, 0);
    chk({nm, ".mstatus"}, csr_mem[12'h300], m_csr[12'h300]);
    chk({nm, ".mtvec"}, csr_mem[12'h305], m_csr[12'h305]);
    chk({nm, ".mepc"}, csr_mem[12'h341], m_csr[12'h341]);
    chk({nm, ".mcause"}, csr_mem[12'h342], m_csr[12'h342]);
  endtask

  logic [11:0] addr_tab [0:6] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h340, 12'hF11, 12'hC00};

  initial begin
    reset = 0; req_valid = 0; req_op = 0; req_addr = 0; req_src = 0;
    req_rs1_zero = 0; req_pc = 0; rsp_ready = 0;
    repeat (2) @(negedge clk);
    chk("reset.req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset.outputs", {26'b0, rsp_valid, csr_wen, csr_ren, csr_jtype, rsp_illegal}, 32'd0);
    chk("reset.rdata", rsp_rdata | rsp_target, 32'd0);
    reset = 1;

    run_txn(3'd0, 12'h305, 32'h80000100, 1'b0, 32'h0, 3, "rw_mtvec");
    run_txn(3'd1, 12'h305, 32'h0, 1'b1, 32'h0, 0, "rd_mtvec");
    run_txn(3'd0, 12'h300, 32'h00001800, 1'b0, 32'h0, 0, "rw_mstatus");
    run_txn(3'd1, 12'h300, 32'h00000008, 1'b0, 32'h0, 1, "rs_mstatus");
    run_txn(3'd2, 12'h300, 32'hFFFFFFFF, 1'b1, 32'h0, 0, "rc_rs1zero");
    run_txn(3'd3, 12'h000, 32'h0, 1'b0, 32'h80000040, 0, "ecall");
    run_txn(3'd0, 12'h341, 32'h80000044, 1'b0, 32'h0, 0, "rw_mepc");
    run_txn(3'd0, 12'h300, 32'h00001880, 1'b0, 32'h0, 0, "rw_mstatus2");
    run_txn(3'd4, 12'h000, 32'h0, 1'b0, 32'h0, 2, "mret");
    run_txn(3'd0, 12'hF11, 32'h0, 1'b0, 32'h0, 0, "rw_readonly");
    run_txn(3'd7, 12'h300, 32'h12345678, 1'b0, 32'h0, 1, "illegal_op");
    run_txn(3'd1, 12'hF11, 32'h0, 1'b1, 32'h0, 0, "rs_readonly_zero");

    for (int n = 0; n < 80; n++) begin
      run_txn(3'($urandom_range(0, 7)), addr_tab[$urandom_range(0, 6)], $urandom,
              1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2), "rand");
    end

    // abort an ECALL while it is writing mepc
    @(negedge clk);
    req_valid = 1; req_op = 3'd3; req_pc = 32'hDEAD_BEE0;
    @(posedge clk); #1;
    req_valid = 0;
    chk("abort.epc_wen", {31'b0, csr_wen}, 32'd1);
    reset = 0;
    #1;
    chk("abort.wen", {31'b0, csr_wen}, 32'd0);
    chk("abort.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("abort.req_ready", {31'b0, req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1;
    repeat (3) @(negedge clk);
    chk("abort.ready_after", {31'b0, req_ready}, 32'd1);
    chk("abort.mcause", csr_mem[12'h342], m_csr[12'h342]);
    chk("abort.mepc", csr_mem[12'h341], m_csr[12'h341]);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
